mem_port_arbiter: RTL

// - Memory-side responder for the pipeline's inst/data request ports. Stages hold

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Inst/data port arbiter onto a single backing-memory port.
// Optional round-robin arbitration: define MEM_ARB_RR_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_read,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_resp,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_mbe,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_resp,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_mbe,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MBE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INST = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_inst_resp;
  logic                r_data_resp;
  logic [DATA_W-1:0]   r_inst_rdata;
  logic [DATA_W-1:0]   r_data_rdata;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [MBE_W-1:0]    r_mbe;
  logic [DATA_W-1:0]   r_wdata;

  logic w_data_req;
  logic w_grant_data;
  logic w_grant_inst;

  assign w_data_req = data_read | data_write;

`ifdef MEM_ARB_RR_EN
  // 1 = data port was granted last
  logic r_last_data;

  // Contention goes to the port not granted last time
  always_comb begin
    w_grant_data = w_data_req & (~inst_read | ~r_last_data);
    w_grant_inst = inst_read & ~w_grant_data;
  end

  // Remember the most recent grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_data <= 1'b1;
    end else if (r_state == S_IDLE && (w_grant_data || w_grant_inst)) begin
      r_last_data <= w_grant_data;
    end
  end
`else
  // Fixed priority: a stalled load/store always drains first
  always_comb begin
    w_grant_data = w_data_req;
    w_grant_inst = inst_read & ~w_data_req;
  end
`endif

  // Main FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_inst_resp  <= 1'b0;
      r_data_resp  <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_addr       <= '0;
      r_mbe        <= '0;
      r_wdata      <= '0;
    end else begin
      r_inst_resp <= 1'b0;
      r_data_resp <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_state     <= S_DATA;
            r_mem_write <= data_write;
            r_mem_read  <= ~data_write;
            r_addr      <= data_addr;
            r_mbe       <= data_write ? data_mbe : {MBE_W{1'b1}};
            r_wdata     <= data_write ? data_wdata : '0;
          end else if (w_grant_inst) begin
            r_state     <= S_INST;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_addr      <= inst_addr;
            r_mbe       <= {MBE_W{1'b1}};
            r_wdata     <= '0;
          end
        end
        S_INST: begin
          if (mem_resp) begin
            r_state      <= S_IDLE;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_inst_resp  <= 1'b1;
            r_inst_rdata <= mem_rdata;
          end
        end
        S_DATA: begin
          if (mem_resp) begin
            r_state     <= S_IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_data_resp <= 1'b1;
            if (r_mem_read) begin
              r_data_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  assign inst_resp  = r_inst_resp;
  assign inst_rdata = r_inst_rdata;
  assign data_resp  = r_data_resp;
  assign data_rdata = r_data_rdata;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_addr;
  assign mem_mbe    = r_mbe;
  assign mem_wdata  = r_wdata;

endmodule
